// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus vector sequencer.
// Contents:
//   seq_state_e   - sequencer FSM states
//   DefInW/...    - default field widths
//   *_BIT/*_LSB   - field offsets within a stored vector at the default widths
package stim_seq_pkg;

  localparam int unsigned DefInW   = 32;
  localparam int unsigned DefCntW  = 4;
  localparam int unsigned DefAddrW = 8;

  // Field positions inside a stored vector at the default widths.
  localparam int unsigned IN_LSB  = 0;
  localparam int unsigned CNT_LSB = DefInW;
  localparam int unsigned REG_BIT = DefInW + DefCntW;
  localparam int unsigned OBS_BIT = DefInW + DefCntW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StApply,
    StDone
  } seq_state_e;

endpackage

// File: rtl/stim_vec_unpack.sv
// Combinational split of one stored vector into the four DUT input fields.
// Ports:
//   vec      in  VEC_W  stored vector
//   in_f     out IN_W   data field,     bits [IN_W-1:0]
//   count_f  out CNT_W  count field,    bits [IN_W+CNT_W-1:IN_W]
//   reg_f    out 1      register flag,  bit VEC_W-2
//   obs_f    out 1      observation flag, bit VEC_W-1
module stim_vec_unpack #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned CNT_W = 4,
  localparam int unsigned VEC_W = IN_W + CNT_W + 2
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IN_W-1:0]  in_f,
  output logic [CNT_W-1:0] count_f,
  output logic             reg_f,
  output logic             obs_f
);

  always_comb begin
    in_f    = vec[IN_W-1:0];
    count_f = vec[IN_W+CNT_W-1:IN_W];
    reg_f   = vec[VEC_W-2];
    obs_f   = vec[VEC_W-1];
  end

endmodule

// File: rtl/stim_vector_sequencer.sv
// Replay controller: walks a vector RAM (one-cycle read latency) and applies
// each stored vector to the DUT input fields, one vector every three cycles
// when the DUT is not stalling.
// Optional feature macro: SEQ_LOOP_EN (continuous looping, start acts as stop).
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   start, num_vec      run request and vector count (latched on accept)
//   stall               DUT not ready; holds the current vector
//   mem_rd, mem_addr    read request to the vector RAM
//   mem_rdata           RAM data, valid the cycle after mem_rd
//   dut_in/count/register/obs  registered DUT fields
//   vec_valid           pulse: new vector on dut_* this cycle
//   busy, done, pc      run status and applied-vector count
module stim_vector_sequencer
  import stim_seq_pkg::*;
#(
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned ADDR_W = DefAddrW,
  localparam int unsigned VEC_W = IN_W + CNT_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic [IN_W-1:0]   dut_in,
  output logic [CNT_W-1:0]  dut_count,
  output logic              dut_register,
  output logic              dut_obs,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pc
);

  seq_state_e state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [ADDR_W:0] num_q, num_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic vec_valid_q, vec_valid_d;
  logic load_en;

  logic [IN_W-1:0]  in_q;
  logic [CNT_W-1:0] count_q;
  logic             reg_q, obs_q;

  logic [IN_W-1:0]  rd_in;
  logic [CNT_W-1:0] rd_count;
  logic             rd_reg, rd_obs;

  stim_vec_unpack #(
    .IN_W  (IN_W),
    .CNT_W (CNT_W)
  ) u_unpack (
    .vec     (mem_rdata),
    .in_f    (rd_in),
    .count_f (rd_count),
    .reg_f   (rd_reg),
    .obs_f   (rd_obs)
  );

`ifdef SEQ_LOOP_EN
  // A stop request seen while stalled is remembered until the vector retires.
  logic stop_q, stop_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stop_q <= 1'b0;
    else        stop_q <= stop_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    num_d       = num_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vec_valid_d = 1'b0;
    load_en     = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
`ifdef SEQ_LOOP_EN
    stop_d      = stop_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_vec != '0) begin
            num_d   = num_vec;
            pc_d    = '0;
            busy_d  = 1'b1;
            state_d = StFetch;
          end else begin
            // Empty run: straight to the done pulse, dut_* untouched.
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q[ADDR_W-1:0];
        state_d  = StLoad;
      end
      StLoad: begin
        load_en     = 1'b1;
        pc_d        = pc_q + 1'b1;
        vec_valid_d = 1'b1;
        state_d     = StApply;
      end
      StApply: begin
`ifdef SEQ_LOOP_EN
        if (start) stop_d = 1'b1;
        if (!stall) begin
          if (start || stop_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (pc_q == num_q) begin
            // Wrap: signal end of pass and restart from address 0.
            done_d  = 1'b1;
            pc_d    = '0;
            state_d = StFetch;
          end else begin
            state_d = StFetch;
          end
        end
`else
        if (!stall) begin
          if (pc_q == num_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
`endif
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
`ifdef SEQ_LOOP_EN
        stop_d  = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      num_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      num_q       <= num_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= '0;
      count_q <= '0;
      reg_q   <= 1'b0;
      obs_q   <= 1'b0;
    end else if (load_en) begin
      in_q    <= rd_in;
      count_q <= rd_count;
      reg_q   <= rd_reg;
      obs_q   <= rd_obs;
    end
  end

  assign dut_in       = in_q;
  assign dut_count    = count_q;
  assign dut_register = reg_q;
  assign dut_obs      = obs_q;
  assign vec_valid    = vec_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_stim_vector_sequencer.sv
// Directed bench for stim_vector_sequencer with a one-cycle-latency RAM model.
module tb_stim_vector_sequencer;

  localparam int unsigned IN_W   = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned VEC_W  = IN_W + CNT_W + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_vec = '0;
  logic              stall = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [VEC_W-1:0]  mem_rdata = '0;
  logic [IN_W-1:0]   dut_in;
  logic [CNT_W-1:0]  dut_count;
  logic              dut_register, dut_obs, vec_valid, busy, done;
  logic [ADDR_W:0]   pc;

  logic [VEC_W-1:0]  ram [256];

  // Reference field split for a chosen vector.
  logic [VEC_W-1:0]  exp_vec = '0;
  logic [IN_W-1:0]   exp_in;
  logic [CNT_W-1:0]  exp_count;
  logic              exp_reg, exp_obs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  stim_vector_sequencer #(
    .IN_W   (IN_W),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_vec      (num_vec),
    .stall        (stall),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .dut_in       (dut_in),
    .dut_count    (dut_count),
    .dut_register (dut_register),
    .dut_obs      (dut_obs),
    .vec_valid    (vec_valid),
    .busy         (busy),
    .done         (done),
    .pc           (pc)
  );

  stim_vec_unpack #(
    .IN_W  (IN_W),
    .CNT_W (CNT_W)
  ) u_ref (
    .vec     (exp_vec),
    .in_f    (exp_in),
    .count_f (exp_count),
    .reg_f   (exp_reg),
    .obs_f   (exp_obs)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = VEC_W'(i) * 38'h1_0000_0101;
    ram[0] = 38'h3F_0000_0001;
    ram[1] = 38'h15_DEADBEEF;
    ram[2] = 38'h00_0000_0000;

    // Reset state.
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_dut_in", 64'(dut_in), 64'd0);
    reset = 1'b1;
    tick(1);

    // Empty run: done next cycle, no RAM access.
    start = 1'b1; num_vec = '0;
    tick(1);
    start = 1'b0;
    check("nv0_done", 64'(done), 64'd1);
    check("nv0_busy", 64'(busy), 64'd0);
    check("nv0_mem_rd", 64'(mem_rd), 64'd0);
    tick(1);
    check("nv0_done_clr", 64'(done), 64'd0);
    check("nv0_mem_rd2", 64'(mem_rd), 64'd0);
    check("nv0_dut_in", 64'(dut_in), 64'd0);
    check("nv0_dut_obs", 64'(dut_obs), 64'd0);

    // Main run, num_vec=3; later num_vec changes and start pulses are ignored.
    start = 1'b1; num_vec = 9'd3;
    tick(1);                                   // cycle 1: FETCH
    start = 1'b0; num_vec = 9'd9;
    check("c1_busy", 64'(busy), 64'd1);
    check("c1_mem_rd", 64'(mem_rd), 64'd1);
    check("c1_mem_addr", 64'(mem_addr), 64'd0);
    tick(1);                                   // cycle 2: LOAD
    check("c2_vec_valid", 64'(vec_valid), 64'd0);
    check("c2_mem_rd", 64'(mem_rd), 64'd0);
    tick(1);                                   // cycle 3: vector 0
    check("c3_vec_valid", 64'(vec_valid), 64'd1);
    check("c3_obs", 64'(dut_obs), 64'd1);
    check("c3_reg", 64'(dut_register), 64'd1);
    check("c3_count", 64'(dut_count), 64'hF);
    check("c3_in", 64'(dut_in), 64'h1);
    check("c3_pc", 64'(pc), 64'd1);
`ifndef SEQ_LOOP_EN
    start = 1'b1;
`endif
    exp_vec = ram[1];
    tick(1);                                   // cycle 4: FETCH
    start = 1'b0;
    check("c4_vec_valid", 64'(vec_valid), 64'd0);
    check("c4_mem_addr", 64'(mem_addr), 64'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);                                   // cycle 6: vector 1
    check("c6_vec_valid", 64'(vec_valid), 64'd1);
    check("c6_in", 64'(dut_in), 64'hDEADBEEF);
    check("c6_count", 64'(dut_count), 64'h5);
    check("c6_reg", 64'(dut_register), 64'd1);
    check("c6_obs", 64'(dut_obs), 64'd0);
    check("c6_in_ref", 64'(dut_in), 64'(exp_in));
    check("c6_count_ref", 64'(dut_count), 64'(exp_count));
    tick(3);                                   // cycle 9: vector 2
    check("c9_vec_valid", 64'(vec_valid), 64'd1);
    check("c9_in", 64'(dut_in), 64'd0);
    check("c9_pc", 64'(pc), 64'd3);
    check("c9_done", 64'(done), 64'd0);
    tick(1);                                   // cycle 10: DONE
    check("c10_done", 64'(done), 64'd1);
    check("c10_busy", 64'(busy), 64'd1);
    check("c10_pc", 64'(pc), 64'd3);
    tick(1);
    check("c11_done", 64'(done), 64'd0);
    check("c11_busy", 64'(busy), 64'd0);
    check("c11_mem_rd", 64'(mem_rd), 64'd0);

    // Stall for 5 cycles in APPLY of vector 1: next vector moves from 9 to 14.
    start = 1'b1; num_vec = 9'd3;
    tick(1);
    start = 1'b0;
    tick(5);                                   // cycle 6
    check("st_c6_vec_valid", 64'(vec_valid), 64'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);                                 // cycles 7..11
      check("st_hold_in", 64'(dut_in), 64'hDEADBEEF);
      check("st_hold_mem_rd", 64'(mem_rd), 64'd0);
      check("st_hold_vv", 64'(vec_valid), 64'd0);
    end
    stall = 1'b0;
    tick(1);                                   // cycle 12: FETCH
    check("st_c12_mem_rd", 64'(mem_rd), 64'd1);
    check("st_c12_addr", 64'(mem_addr), 64'd2);
    tick(1);
    check("st_c13_vv", 64'(vec_valid), 64'd0);
    tick(1);                                   // cycle 14
    check("st_c14_vv", 64'(vec_valid), 64'd1);
    check("st_c14_pc", 64'(pc), 64'd3);
    tick(1);
    check("st_c15_done", 64'(done), 64'd1);
    tick(1);

    // Reset during LOAD of vector 2, then replay from address 0.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);                                   // cycle 8: LOAD
    check("rs_c8_pc", 64'(pc), 64'd2);
    check("rs_c8_vv", 64'(vec_valid), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_pc", 64'(pc), 64'd0);
    check("rs_in", 64'(dut_in), 64'd0);
    check("rs_count", 64'(dut_count), 64'd0);
    check("rs_reg", 64'(dut_register), 64'd0);
    check("rs_mem_rd", 64'(mem_rd), 64'd0);
    tick(1);
    check("rs_no_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick(1);
    check("rs_no_done2", 64'(done), 64'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("rp_addr", 64'(mem_addr), 64'd0);
    check("rp_mem_rd", 64'(mem_rd), 64'd1);
    tick(2);
    check("rp_in", 64'(dut_in), 64'h1);
    check("rp_pc", 64'(pc), 64'd1);
    tick(7);
    check("rp_done", 64'(done), 64'd1);
    tick(1);

`ifdef SEQ_LOOP_EN
    // Looping pass of two vectors, stopped by a start pulse in APPLY.
    start = 1'b1; num_vec = 9'd2;
    tick(1);
    start = 1'b0;
    check("lp_c1_addr", 64'(mem_addr), 64'd0);
    tick(3);
    check("lp_c4_addr", 64'(mem_addr), 64'd1);
    tick(3);
    check("lp_c7_done", 64'(done), 64'd1);
    check("lp_c7_addr", 64'(mem_addr), 64'd0);
    check("lp_c7_busy", 64'(busy), 64'd1);
    tick(3);
    check("lp_c10_done", 64'(done), 64'd0);
    check("lp_c10_addr", 64'(mem_addr), 64'd1);
    tick(3);
    check("lp_c13_done", 64'(done), 64'd1);
    tick(2);
    check("lp_c15_vv", 64'(vec_valid), 64'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("lp_stop_done", 64'(done), 64'd1);
    check("lp_stop_mem_rd", 64'(mem_rd), 64'd0);
    tick(1);
    check("lp_stop_busy", 64'(busy), 64'd0);
    check("lp_stop_done_clr", 64'(done), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_vector_sequencer.md
Name: stim_vector_sequencer

Overview:
- Synthesizable replay controller that walks a vector memory and applies each stored vector to the design-under-test input fields.
- Fields driven are data, count, register flag and observation flag.
- Sits between a vector RAM (one-cycle read latency) and the DUT.
- Owns the vector program counter, start/done sequencing and stall hold-off.

Parameters:
- IN_W, 32, width of the DUT data input field.
- CNT_W, 4, width of the DUT count field.
- ADDR_W, 8, vector memory address width.
- VEC_W, IN_W+CNT_W+2 (localparam, not overridable), stored vector width (38 at defaults).

Ports:
- clk  in  1  — single clock; all logic on rising edge.
- reset  in  1  — asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- start  in  1  — one-cycle pulse; begins a run when idle.
- num_vec  in  ADDR_W+1  — vector count for the run, latched on accepted start.
- stall  in  1  — DUT not ready; holds current vector while high.
- mem_rd  out  1  — read strobe to vector RAM.
- mem_addr  out  ADDR_W  — read address.
- mem_rdata  in  VEC_W  — read data, valid the cycle after mem_rd.
- dut_in  out  IN_W  — vector bits [IN_W-1:0].
- dut_count  out  CNT_W  — vector bits [IN_W+CNT_W-1:IN_W].
- dut_register  out  1  — vector bit VEC_W-2.
- dut_obs  out  1  — vector bit VEC_W-1.
- vec_valid  out  1  — one-cycle pulse; a new vector appeared on dut_* this cycle.
- busy  out  1  — high from accepted start until done.
- done  out  1  — one-cycle pulse at run end.
- pc  out  ADDR_W+1  — count of vectors applied in the current run.

Behaviour:
- Reset (reset=0): state IDLE; pc=0; all outputs 0 (dut_*, mem_rd, mem_addr, vec_valid, busy, done). Reset mid-run aborts immediately with no done pulse.
- State IDLE:
  - start=1 and num_vec!=0: latch num_vec, pc=0, busy=1, go to FETCH.
  - start=1 and num_vec==0: go to DONE without touching dut_*.
- State FETCH: mem_rd=1, mem_addr=pc[ADDR_W-1:0] (combinational from state); go to LOAD.
- State LOAD:
  - Register mem_rdata fields onto dut_*, pc<=pc+1, vec_valid<=1.
  - Go to APPLY; new values visible the cycle after LOAD.
- State APPLY:
  - vec_valid high for this first cycle only.
  - stall=1: stay in APPLY, dut_* held.
  - stall=0 and pc==latched num_vec: go to DONE.
  - otherwise: go to FETCH.
- State DONE: done=1 for one cycle, busy=0 on exit, go to IDLE. dut_* keep the last vector until the next run loads.
- Cadence: with stall low, vectors are spaced exactly 3 cycles. The first dut_* change occurs 3 cycles after the start cycle.
- start while busy is ignored (except stop under SEQ_LOOP_EN). num_vec changes after start are ignored.
- num_vec = 2^ADDR_W is legal: addresses 0..255; pc reaches 256 without wrapping.
- stall is sampled only in APPLY; stall during FETCH/LOAD has no effect.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - In APPLY with stall=0 and pc==num_vec: pulse done for one cycle, clear pc to 0, go to FETCH, busy stays 1.
  - start=1 sampled in APPLY acts as stop: the run ends via DONE after the current vector, regardless of pc.
- Undefined: single pass as above; start during a run is ignored.

Decomposition:
- Package stim_seq_pkg:
  - state enum: IDLE, FETCH, LOAD, APPLY, DONE.
  - default IN_W/CNT_W/ADDR_W.
  - field offset constants: OBS_BIT, REG_BIT, CNT_LSB, IN_LSB.
- Sub-module stim_vec_unpack: combinational slice of VEC_W into the four DUT fields, reused by the bench's reference model.

Test Plan:
- Reset then start, num_vec=3, RAM[0..2] = 38'h3F_0000_0001 / 38'h15_DEADBEEF / 38'h00_0000_0000:
  - vec_valid pulses at cycles 3, 6, 9.
  - first vector: dut_obs=1, dut_register=1, dut_count=4'hF, dut_in=1.
  - done pulses at cycle 10; pc=3.
- start with num_vec=0 -> done pulses next cycle; mem_rd never asserted; dut_* stay 0.
- Hold stall=1 for 5 cycles in APPLY of vector 1 -> dut_* unchanged, no mem_rd, next vec_valid delayed by exactly 5 cycles.
- Assert reset low during LOAD of vector 2 -> all outputs 0 immediately, no done; a fresh start replays from address 0.
- start pulses while busy -> ignored, run completes normally.
- SEQ_LOOP_EN, num_vec=2:
  - done pulses every 6 cycles, addresses 0,1,0,1...
  - start pulse in APPLY -> final done, busy=0.
